alu_seq: RTL
============

# alu_seq

Parametrised, registered successor to the 4-bit combinational ALU. It runs eight operations on W-bit unsigned operands: add, sub, and, or, xor, logical shift left, logical shift right, and an iterative shift-add multiply. Operands enter through a valid/ready handshake and results leave through one. The block sits between an operand source (switch/register file) and a result sink (display or accumulator), and keeps the legacy mode encoding 0–3 unchanged.

## Interface
- W, default 4: operand and result width; legal W ≥ 2.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  3  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 mul.
- a  in  W  operand A, unsigned.
- b  in  W  operand B, unsigned; for shifts it is the shift amount.
- out_valid  out  1  result held on c/co/zero.
- out_ready  in  1  sink accepts the result.
- c  out  W  result.
- co  out  1  carry/status bit; meaning depends on op (see Operation).
- zero  out  1  c == 0, registered with c.

## Operation
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready = 1.
  - in_valid && in_ready latches op, a, b.
  - op ≠ 7: result computed and registered on the same edge, go to DONE.
  - op = 7: go to MUL.
- MUL:
  - Shift-add over W iterations, one per cycle; 2W-bit product accumulator.
  - After the W-th iteration, c/co/zero are written and the FSM goes to DONE.
- DONE:
  - out_valid = 1; c/co/zero stable.
  - out_ready = 1 → transfer; go to IDLE on that edge.
  - out_ready = 0 → hold indefinitely.
- Arithmetic rules:
  - add: {co,c} = a + b.
  - sub: {co,c} = a + ~b + 1; co = 1 means no borrow (a ≥ b).
  - and/or/xor: bitwise; co = 0.
  - shl/shr: shift by full unsigned b. b ≥ W gives c = 0. co = OR of every bit shifted out, so co = |a when b ≥ W, and co = 0 when b = 0.
  - mul: c = low W bits of a·b; co = OR of the high W bits (overflow indicator).
- Inputs are ignored while in_ready = 0. Changes on a/b/op after acceptance have no effect.
- rst in any state, including mid-MUL: next state IDLE, the accumulator and iteration counter are cleared, and all outputs go to their reset values. No partial result is ever presented.

## Timing
- Reset values: in_ready = 1, out_valid = 0, c = 0, co = 0, zero = 1. Iteration counter and accumulator = 0.
- Single-cycle ops: accepted at edge k, out_valid high from edge k (visible in cycle k+1). Latency 1.
- mul: accepted at edge k, out_valid high from edge k+W. Latency W+1 cycles to first valid cycle.
- Throughput: back-to-back single ops with out_ready held high complete one op every 2 cycles. DONE→IDLE takes one edge, and in_ready is not asserted in DONE.
- Simultaneous in_valid and out_ready in DONE: only the output transfer occurs. The input is accepted in the following IDLE cycle if in_valid is still high.
- Counter width is $clog2(W)+1. It wraps nowhere: it is reset on entry to MUL and terminates at W.

## Structure
- Package alu_pkg:
  - op localparams: OP_ADD = 0 through OP_MUL = 7.
  - State encoding: IDLE, MUL, DONE.
- Sub-module alu_mul_iter (W parameter):
  - Ports: start, a, b, busy, done, product[2W-1:0].
  - Contains the counter and accumulator.
  - Resets with the same clk/rst.
- The top level holds the FSM, the single-cycle combinational datapath, and the output registers.

## Test plan
- Reset (W=4): hold rst 2 cycles mid-stream → in_ready=1, out_valid=0, c=0, co=0, zero=1.
- Add/sub (W=4):
  - 9+8 → c=0x1, co=1, zero=0.
  - 5−3 → c=0x2, co=1.
  - 3−5 → c=0xE, co=0.
  - 7−7 → c=0, co=1, zero=1.
- Logic/shift (W=4):
  - and 0xC,0xA → 0x8.
  - xor 0xC,0xA → 0x6.
  - shl 0xB by 2 → c=0xC, co=1.
  - shr 0x4 by 2 → c=0x1, co=0.
  - shr 0x5 by 9 → c=0, co=1.
- Multiply (W=4): 13×11 (=0x8F) → out_valid exactly 4 edges after accept, c=0xF, co=1. 3×5 → c=0xF, co=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → c stable, in_ready=0, new in_valid ignored. Release → one transfer, then the next op is accepted.
- Reset mid-multiply: assert rst at iteration 2 → next cycle IDLE with reset outputs. A following 2×2 mul → c=0x4, co=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the registered ALU.
// The low four opcodes match the legacy 4-bit ALU mode encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle over W cycles.
// product is the accumulator value after the current iteration, so the owner can capture it when done is high.
module alu_mul_iter #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int CW = $clog2(W) + 1;

    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic           busy_q;

    assign busy    = busy_q;
    assign done    = busy_q && (cnt == CW'(W - 1));
    assign product = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered W-bit ALU with valid/ready handshakes on both sides.
// Single-cycle ops register their result on the accept edge; mul runs W cycles in alu_mul_iter.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c,
    output logic         co,
    output logic         zero
);

    state_t         state_q, state_d;
    logic [W-1:0]   alu_c, wr_c;
    logic           alu_co, wr_co, wr_en;
    logic [W:0]     sum;
    logic [2*W-1:0] shl_ext, shr_ext, product;
    logic           big_shift, mul_start, mul_busy, mul_done;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign mul_start = (state_q == IDLE) && in_valid && (op == OP_MUL);

    alu_mul_iter #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    // Shifts use a double-width window so the bits pushed out land in the other half for co.
    always_comb begin
        alu_c     = '0;
        alu_co    = 1'b0;
        sum       = '0;
        big_shift = (b >= W'(W));
        shl_ext   = {{W{1'b0}}, a} << b;
        shr_ext   = {a, {W{1'b0}}} >> b;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                alu_c  = sum[W-1:0];
                alu_co = sum[W];
            end
            OP_SUB: begin
                sum    = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                alu_c  = sum[W-1:0];
                alu_co = sum[W];
            end
            OP_AND: alu_c = a & b;
            OP_OR:  alu_c = a | b;
            OP_XOR: alu_c = a ^ b;
            OP_SHL: begin
                alu_c  = big_shift ? '0 : shl_ext[W-1:0];
                alu_co = big_shift ? |a : |shl_ext[2*W-1:W];
            end
            OP_SHR: begin
                alu_c  = big_shift ? '0 : shr_ext[2*W-1:W];
                alu_co = big_shift ? |a : |shr_ext[W-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_c    = '0;
        wr_co   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        state_d = MUL;
                    end else begin
                        state_d = DONE;
                        wr_en   = 1'b1;
                        wr_c    = alu_c;
                        wr_co   = alu_co;
                    end
                end
            end
            MUL: begin
                if (mul_busy && mul_done) begin
                    state_d = DONE;
                    wr_en   = 1'b1;
                    wr_c    = product[W-1:0];
                    wr_co   = |product[2*W-1:W];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c       <= '0;
            co      <= 1'b0;
            zero    <= 1'b1;
        end else begin
            state_q <= state_d;
            if (wr_en) begin
                c    <= wr_c;
                co   <= wr_co;
                zero <= (wr_c == '0);
            end
        end
    end

endmodule
